fill_blitter: RTL and testbench

FILL_BLITTER -- requirements
Module: fill_blitter

---
 rtl/fill_blitter.sv | 106 ++++++++++
 tb/tb_fill_blitter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_blitter.sv
// rtl/fill_blitter.sv - rectangle fill engine streaming raster-order pixel writes to a framebuffer
// Define FILL_BLITTER_CLIP_EN to clip rectangles to the H_RES x V_RES framebuffer.
module fill_blitter #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [16:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  localparam logic [16:0] ROW_STEP = 17'(H_RES);

  logic [8:0]  w_eff, w_reg, col_left;
  logic [7:0]  h_eff, row_left;
  logic [16:0] row_base, start_addr;
  logic        accept, hs, last_col, last_pix;

`ifdef FILL_BLITTER_CLIP_EN
  localparam logic [9:0] HR = 10'(H_RES);
  localparam logic [8:0] VR = 9'(V_RES);
  logic [9:0] x_room;
  logic [8:0] y_room;

  always_comb begin
    x_room = ({1'b0, cmd_x} >= HR) ? 10'd0 : HR - {1'b0, cmd_x};
    y_room = ({1'b0, cmd_y} >= VR) ? 9'd0 : VR - {1'b0, cmd_y};
    w_eff  = ({1'b0, cmd_w} < x_room) ? cmd_w : x_room[8:0];
    h_eff  = ({1'b0, cmd_h} < y_room) ? cmd_h : y_room[7:0];
  end
`else
  assign w_eff = cmd_w;
  assign h_eff = cmd_h;
`endif

  // One multiply per command for the start address; per-pixel stepping is additive.
  assign start_addr = 17'(32'(cmd_y) * 32'(ROW_STEP) + 32'(cmd_x));

  assign accept   = cmd_valid && (state == IDLE);
  assign hs       = (state == RUN) && wr_ready;
  assign last_col = (col_left == 9'd1);
  assign last_pix = last_col && (row_left == 8'd1);

  assign cmd_ready = (state == IDLE);
  assign wr_valid  = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = (w_eff == 9'd0 || h_eff == 8'd0) ? DONE : RUN;
      RUN:  if (wr_ready && last_pix) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= '0;
      wr_data  <= '0;
      row_base <= '0;
      w_reg    <= '0;
      col_left <= '0;
      row_left <= '0;
    end else if (accept) begin
      wr_addr  <= start_addr;
      row_base <= start_addr;
      wr_data  <= cmd_color;
      w_reg    <= w_eff;
      col_left <= w_eff;
      row_left <= h_eff;
    end else if (hs) begin
      // Address after the final pixel runs on to the next row, but wr_valid is already low.
      if (last_col) begin
        wr_addr  <= row_base + ROW_STEP;
        row_base <= row_base + ROW_STEP;
        col_left <= w_reg;
        row_left <= row_left - 8'd1;
      end else begin
        wr_addr  <= wr_addr + 17'd1;
        col_left <= col_left - 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_fill_blitter.sv
// tb/tb_fill_blitter.sv - scoreboard testbench for fill_blitter
`timescale 1ns/1ps
module tb_fill_blitter;
  localparam int H = 320;
  localparam int V = 240;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  fill_blitter #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [24:0] exp_q[$];
  int pass_cnt = 0, total_cnt = 0;
  int wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0, acc_cyc = 0;
  int ready_mode = 0, phase = 0;
  logic        stall_prev = 1'b0;
  logic [16:0] stall_addr = '0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every write handshake and logs timing events.
  always @(negedge clk) begin
    logic [24:0] e;
    if (!rst) begin
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) check("unexpected_write", int'(wr_addr), -1);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(wr_addr), int'(e[24:8]));
          check("wr_data", int'(wr_data), int'(e[7:0]));
        end
        if (wr_cnt == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_cnt++;
      end
      if (stall_prev && wr_valid) check("stall_hold_addr", int'(wr_addr), int'(stall_addr));
      stall_prev = wr_valid && !wr_ready;
      stall_addr = wr_addr;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cmd_valid && cmd_ready) begin acc_cnt++; acc_cyc = cyc + 1; end
    end else stall_prev = 1'b0;
  end

  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) wr_ready = 1'b1;
      else begin
        wr_ready = (phase == 0);
        phase = (phase + 1) % 3;
      end
    end
  end

  task automatic push_exp(input int x, input int y, input int w, input int h,
                          input logic [7:0] c, output int n);
    int we, he;
    logic [16:0] a;
    we = w; he = h;
`ifdef FILL_BLITTER_CLIP_EN
    we = (x >= H) ? 0 : ((w < H - x) ? w : H - x);
    he = (y >= V) ? 0 : ((h < V - y) ? h : V - y);
`endif
    n = we * he;
    for (int r = 0; r < he; r++)
      for (int cc = 0; cc < we; cc++) begin
        a = 17'(((y + r) * H + x + cc) % 131072);
        exp_q.push_back({a, c});
      end
  endtask

  task automatic set_fields(input int x, input int y, input int w, input int h, input logic [7:0] c);
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = c;
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input logic [7:0] c, input int mode, output int n);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    ready_mode = mode; phase = 0; wr_cnt = 0;
    push_exp(x, y, w, h, c, n);
    set_fields(x, y, w, h, c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    set_fields(511, 255, 511, 255, 8'h5A);
  endtask

  task automatic wait_done(input string name, input int budget);
    int start, k;
    start = done_cnt; k = 0;
    while (done_cnt == start && k < budget) begin @(posedge clk); k++; end
    if (done_cnt == start) check(name, 0, 1);
  endtask

  initial begin
    int n, a, a1, d0, k;
    rst = 1'b1; cmd_valid = 1'b0;
    set_fields(0, 0, 0, 0, 8'h00);
    #1;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_wr_valid", int'(wr_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic 3x2 fill at full throughput
    d0 = done_cnt;
    run_cmd(10, 2, 3, 2, 8'hE0, 0, n);
    a = acc_cyc;
    wait_done("t1_done_timeout", 50);
    check("t1_writes", wr_cnt, 6);
    check("t1_first_cyc", first_wr_cyc - a, 0);
    check("t1_last_cyc", last_wr_cyc - a, 5);
    check("t1_done_lat", done_cyc - last_wr_cyc, 1);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_queue_left", exp_q.size(), 0);

    // Same fill with wr_ready pattern 1,0,0
    run_cmd(10, 2, 3, 2, 8'hE0, 1, n);
    wait_done("t2_done_timeout", 100);
    check("t2_writes", wr_cnt, 6);
    check("t2_done_lat", done_cyc - last_wr_cyc, 1);
    check("t2_queue_left", exp_q.size(), 0);

    // Zero-width and zero-height commands
    run_cmd(5, 5, 0, 5, 8'h33, 0, n);
    a = acc_cyc;
    wait_done("t3_done_timeout", 20);
    check("t3_done_cyc", done_cyc - a, 0);
    #1 check("t3_ready_back", int'(cmd_ready), 1);
    check("t3_writes", wr_cnt, 0);
    run_cmd(5, 5, 4, 0, 8'h33, 0, n);
    wait_done("t3b_done_timeout", 20);
    check("t3b_writes", wr_cnt, 0);

`ifdef FILL_BLITTER_CLIP_EN
    run_cmd(318, 239, 5, 4, 8'h1F, 0, n);
    wait_done("t4_done_timeout", 50);
    check("t4_clip_writes", wr_cnt, 2);
    check("t4_queue_left", exp_q.size(), 0);
    run_cmd(320, 0, 4, 4, 8'h1F, 0, n);
    wait_done("t4b_done_timeout", 20);
    check("t4b_clip_writes", wr_cnt, 0);
`else
    run_cmd(318, 239, 5, 1, 8'h1F, 0, n);
    wait_done("t4_done_timeout", 50);
    check("t4_noclip_writes", wr_cnt, 5);
    run_cmd(0, 255, 1, 200, 8'h42, 0, n);
    wait_done("t4b_done_timeout", 400);
    check("t4b_wrap_writes", wr_cnt, n);
    check("t4b_queue_left", exp_q.size(), 0);
`endif

    // Reset mid-command after three writes
    d0 = done_cnt;
    run_cmd(10, 2, 3, 2, 8'hE0, 0, n);
    k = 0;
    while (wr_cnt < 3 && k < 50) begin @(negedge clk); #1; k++; end
    check("t5_three_writes", wr_cnt, 3);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("t5_wr_valid", int'(wr_valid), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_cmd_ready", int'(cmd_ready), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_no_more_writes", wr_cnt, 3);
    run_cmd(7, 1, 2, 2, 8'h1C, 0, n);
    wait_done("t5b_done_timeout", 50);
    check("t5b_writes", wr_cnt, 4);
    check("t5b_queue_left", exp_q.size(), 0);

    // Back-to-back with cmd_valid held high
    @(posedge clk); #1;
    ready_mode = 0; wr_cnt = 0; d0 = done_cnt;
    push_exp(10, 2, 3, 2, 8'hE0, n);
    push_exp(0, 0, 2, 1, 8'h03, n);
    set_fields(10, 2, 3, 2, 8'hE0);
    cmd_valid = 1'b1;
    k = acc_cnt; a = 0;
    while (acc_cnt == k && a < 20) begin @(posedge clk); a++; end
    a1 = acc_cyc;
    #1 set_fields(0, 0, 2, 1, 8'h03);
    k = acc_cnt; a = 0;
    while (acc_cnt == k && a < 40) begin @(posedge clk); a++; end
    check("t6_second_accept", acc_cnt - k, 1);
    check("t6_accept_gap", acc_cyc - a1, 8);
    #1 cmd_valid = 1'b0;
    wait_done("t6_done_timeout", 50);
    check("t6_writes", wr_cnt, 8);
    check("t6_done_cnt", done_cnt - d0, 2);
    check("t6_queue_left", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
